// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable serial pattern detector with a match counter.
// A configuration (pattern, length, target) is accepted in IDLE; in RUN every
// qualified serial bit is shifted into a history window and compared against
// the low 'len' bits of the pattern. Overlapping matches count. A non-zero
// target ends the run through a one-cycle DONE state.
module seq_det_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [7:0]       cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             din_valid,
  input  logic             din,
  input  logic             abort,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic [CNT_W-1:0] target_q, target_d;
  // Only the seven most recent bits are stored: together with the incoming
  // din they form the full 8-bit post-shift window; the bit that would sit
  // above them is shifted out before it can ever be compared.
  logic [6:0]       hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             match_q, match_d;
  logic             err_q, err_d;

  logic [7:0]       hist_shift;
  logic [7:0]       len_mask;
  logic [3:0]       fill_inc;
  logic [CNT_W-1:0] count_inc;
  logic             cfg_legal;
  logic             bit_hit;

  // Datapath helpers: post-shift window, saturating fill and the match test.
  always_comb begin
    cfg_legal  = (cfg_len != 4'd0) && (cfg_len <= 4'd8);
    hist_shift = {hist_q, din};
    fill_inc   = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
    len_mask   = 8'hFF >> (4'd8 - len_q);
    bit_hit    = (fill_inc >= len_q) && (((hist_shift ^ pat_q) & len_mask) == 8'h00);
    count_inc  = (count_q == CNT_MAX) ? CNT_MAX : count_q + 1'b1;
  end

  // Next-state and register-update decisions for the controller FSM.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    target_d = target_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    count_d  = count_q;
    match_d  = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          if (cfg_legal) begin
            pat_d    = cfg_pattern;
            len_d    = cfg_len;
            target_d = cfg_target;
            hist_d   = 7'd0;
            fill_d   = 4'd0;
            count_d  = '0;
            err_d    = 1'b0;
            state_d  = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Abort wins over a qualifying bit arriving in the same cycle.
        if (abort) begin
          state_d = S_IDLE;
        end else if (din_valid) begin
          hist_d = hist_shift[6:0];
          fill_d = fill_inc;
          if (bit_hit) begin
            match_d = 1'b1;
            count_d = count_inc;
            if ((target_q != '0) && (count_inc == target_q)) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pat_q    <= 8'd0;
      len_q    <= 4'd0;
      target_q <= '0;
      hist_q   <= 7'd0;
      fill_q   <= 4'd0;
      count_q  <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      target_q <= target_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      match_q  <= match_d;
      err_q    <= err_d;
    end
  end

  assign cfg_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign match       = match_q;
  assign match_count = count_q;
  assign err         = err_q;

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, setting the match-counter and target width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port cfg_valid  input  1  configuration offered.
REQ-005 SHALL have port cfg_ready  output  1  controller accepts configuration (high only in IDLE).
REQ-006 SHALL have port cfg_pattern  input  8  pattern; bit[len-1] is the first serial bit, bit0 the last.
REQ-007 SHALL have port cfg_len  input  4  pattern length; legal range 1..8.
REQ-008 SHALL have port cfg_target  input  CNT_W  matches before completion; 0 = unlimited.
REQ-009 SHALL have port din_valid  input  1  serial bit qualifier.
REQ-010 SHALL have port din  input  1  serial data bit.
REQ-011 SHALL have port abort  input  1  terminate a run.
REQ-012 SHALL have port match  output  1  registered one-cycle match pulse.
REQ-013 SHALL have port match_count  output  CNT_W  matches in the current or last run.
REQ-014 SHALL have port busy  output  1  high in RUN and DONE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the target is reached.
REQ-016 SHALL have port err  output  1  sticky flag for an illegal configuration.

Function
REQ-017 SHALL implement three states: IDLE, RUN, DONE.
REQ-018 IDLE: cfg_valid&cfg_ready with cfg_len in 1..8 SHALL latch pattern/len/target, clear the history register, fill counter and match_count, clear err, and enter RUN next cycle.
REQ-019 IDLE: cfg_valid with cfg_len of 0 or >8 SHALL set err, latch nothing, and remain in IDLE.
REQ-020 RUN: each din_valid cycle SHALL shift din into the 8-bit history (hist <= {hist[6:0],din}) and increment fill, saturating at 8.
REQ-021 RUN: a match SHALL occur when post-shift fill >= len and post-shift hist[len-1:0] == pattern[len-1:0]; overlapping matches SHALL count.
REQ-022 On a match, match SHALL be high for exactly the cycle after the qualifying bit is sampled, and match_count SHALL increment on the same edge.
REQ-023 With target=0, match_count SHALL saturate at 2^CNT_W-1 while match pulses continue.
REQ-024 With target!=0, the match that makes match_count equal target SHALL move to DONE; done SHALL be high during DONE (coinciding with that match pulse); DONE SHALL return to IDLE after one cycle.
REQ-025 din_valid=0 SHALL leave history, fill, count and state unchanged.
REQ-026 din/din_valid SHALL be ignored in IDLE and DONE.
REQ-027 abort in RUN SHALL return to IDLE next cycle without asserting done; abort SHALL win over a same-cycle qualifying bit (no match, no count increment); match_count SHALL otherwise be retained.
REQ-028 cfg_valid outside IDLE SHALL be ignored (cfg_ready=0).
REQ-029 match_count SHALL hold its final value in IDLE until the next accepted configuration.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE and clear history, fill, match_count, match, done and err; cfg_ready SHALL be 1 and busy 0 in the following cycle.
REQ-031 rst during RUN or DONE SHALL abandon the run with no done pulse; rst SHALL take precedence over every other input.

Verification
REQ-032 cfg pattern=8'b1011, len=4, target=0; bits 1,0,1,1,0,1,1 consecutive -> match after bits 4 and 7, match_count=2, busy stays 1.
REQ-033 cfg pattern=8'b11, len=2, target=2; bits 1,1,1,1 -> match after bits 2 and 3; done with the 2nd match; IDLE next cycle; count=2; bit 4 ignored.
REQ-034 cfg_len=0 with cfg_valid -> err=1, cfg_ready stays 1, busy=0; then a legal config -> err=0, RUN entered.
REQ-035 pattern=8'b101, len=3; bits 1,0,1 with din_valid low for 2 cycles between each -> exactly one match, count=1.
REQ-036 pattern=8'b11, len=2; abort asserted with the 2nd valid '1' -> no match, count=0, IDLE next cycle, done=0.
REQ-037 rst asserted mid-RUN with count=3 -> next cycle count=0, match=0, err=0, cfg_ready=1, busy=0.
